// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the EX-stage multiply/divide unit.
//   MD_XLEN     : default datapath width (operands, HI, LO)
//   md_op_e     : mul/div opcode encoding presented on the op bus
//   md_state_e  : state encoding of the iterative mul/div sequencer
package cpu_pkg;

    localparam int MD_XLEN = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Bus between the EX pipeline stage (master) and the mul/div unit (slave).
//   start/op/rs_val/rt_val : issue an op (start is a one-cycle pulse)
//   flush                  : abort any in-flight op
//   hi_we/lo_we/wr_data    : MTHI/MTLO writes
//   rd_hilo                : MFHI/MFLO present in EX this cycle
//   busy/stall_req         : op in flight / freeze request to hazard unit
//   done/div_by_zero       : completion pulse and its divide-by-zero flag
//   hi/lo                  : architectural HI/LO registers
// Handshake: an op is taken on a rising edge where start=1, flush=0 and
// busy=0. If start is raised while busy=1, stall_req goes high in that same
// cycle, the op is not taken, and the issuer must hold and re-present it
// once busy=0. done is a single-cycle pulse; hi/lo already hold the result.
interface ex_muldiv_unit_if
    import cpu_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) ();

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic            flush;
    logic            hi_we;
    logic            lo_we;
    logic [XLEN-1:0] wr_data;
    logic            rd_hilo;
    logic            busy;
    logic            stall_req;
    logic            done;
    logic            div_by_zero;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, flush, hi_we, lo_we, wr_data, rd_hilo,
        input  busy, stall_req, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, flush, hi_we, lo_we, wr_data, rd_hilo,
        output busy, stall_req, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage. Runs MULT/MULTU/DIV/DIVU
// one bit per cycle (XLEN cycles), then a sign-fix cycle that writes HI/LO.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   md  : slave side of ex_muldiv_unit_if (issue, flush, MTHI/MTLO, status, HI/LO)
module ex_muldiv_unit
    import cpu_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic             clk,
    input  logic             rst,
    ex_muldiv_unit_if.slave  md
);

    localparam int CW = $clog2(XLEN);

    md_state_e       state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            is_div_q, neg_res, neg_rem, zero_div;
    logic [XLEN-1:0] a_mag, b_mag, rs_orig;
    // acc_hi: running partial product (mul) or partial remainder (div);
    // the extra top bit holds the carry of the shift-add step.
    logic [XLEN:0]   acc_hi;
    // acc_lo: multiplier shifting out (mul) or dividend shifting out while
    // quotient bits shift in (div).
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] hi_q, lo_q;
    logic            done_q, dbz_q;

    logic            accept, last, is_div_in, signed_in, rs_neg, rt_neg;
    logic [XLEN-1:0] rs_mag, rt_mag;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic            q_bit;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, res_hi, res_lo;

    assign accept    = (state == MD_IDLE) && md.start && !md.flush;
    assign last      = (cnt == CW'(XLEN - 1));
    assign is_div_in = (md.op == MD_DIV) || (md.op == MD_DIVU);
    assign signed_in = (md.op == MD_MULT) || (md.op == MD_DIV);
    assign rs_neg    = signed_in && md.rs_val[XLEN-1];
    assign rt_neg    = signed_in && md.rt_val[XLEN-1];
    assign rs_mag    = rs_neg ? -md.rs_val : md.rs_val;
    assign rt_mag    = rt_neg ? -md.rt_val : md.rt_val;

    // One iteration step. Multiply: add multiplicand when the multiplier LSB
    // is set, then shift the whole {acc_hi, acc_lo} right. Divide: shift the
    // next dividend bit into the remainder and keep the subtraction only when
    // it did not borrow (restoring division).
    assign mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, a_mag} : '0);
    assign div_shift = {acc_hi[XLEN-1:0], acc_lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_mag};
    assign q_bit     = !div_diff[XLEN];

    // Sign correction applied in FIX. Magnitudes of the most-negative value
    // stay representable as unsigned, so MIN / -1 naturally yields MIN, 0.
    always_comb begin
        res_hi   = '0;
        res_lo   = '0;
        prod     = {acc_hi[XLEN-1:0], acc_lo};
        prod_fix = neg_res ? -prod : prod;
        quo_fix  = neg_res ? -acc_lo : acc_lo;
        rem_fix  = neg_rem ? -acc_hi[XLEN-1:0] : acc_hi[XLEN-1:0];
        if (!is_div_q) begin
            {res_hi, res_lo} = prod_fix;
        end else if (zero_div) begin
            res_hi = rs_orig;
            res_lo = '1;
        end else begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= MD_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            MD_IDLE: if (accept) state_nxt = MD_RUN;
            MD_RUN:  begin
                if (md.flush)  state_nxt = MD_IDLE;
                else if (last) state_nxt = MD_FIX;
            end
            MD_FIX:  state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            is_div_q <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            zero_div <= 1'b0;
            a_mag    <= '0;
            b_mag    <= '0;
            rs_orig  <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            unique case (state)
                MD_IDLE: begin
                    if (accept) begin
                        // A taken start drops any same-cycle MTHI/MTLO.
                        cnt      <= '0;
                        is_div_q <= is_div_in;
                        neg_res  <= rs_neg ^ rt_neg;
                        neg_rem  <= rs_neg;
                        zero_div <= (md.rt_val == '0);
                        a_mag    <= rs_mag;
                        b_mag    <= rt_mag;
                        rs_orig  <= md.rs_val;
                        acc_hi   <= '0;
                        acc_lo   <= is_div_in ? rs_mag : rt_mag;
                    end else begin
                        if (md.hi_we) hi_q <= md.wr_data;
                        if (md.lo_we) lo_q <= md.wr_data;
                    end
                end
                MD_RUN: begin
                    cnt <= cnt + CW'(1);
                    if (!is_div_q) begin
                        acc_hi <= {1'b0, mul_sum[XLEN:1]};
                        acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                    end else begin
                        acc_hi <= q_bit ? div_diff : div_shift;
                        acc_lo <= {acc_lo[XLEN-2:0], q_bit};
                    end
                end
                MD_FIX: begin
                    if (!md.flush) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                        dbz_q  <= is_div_q && zero_div;
                    end
                end
                default: ;
            endcase
        end
    end

    assign md.busy        = (state != MD_IDLE);
    assign md.stall_req   = md.busy && (md.start || md.rd_hilo || md.hi_we || md.lo_we);
    assign md.done        = done_q;
    assign md.div_by_zero = dbz_q;
    assign md.hi          = hi_q;
    assign md.lo          = lo_q;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative multiply/divide unit for the EX stage of the 5-stage pipelined CPU. It executes MULT/MULTU/DIV/DIVU one bit per cycle, owns the HI/LO architectural registers, and services MTHI/MTLO writes and MFHI/MFLO reads. It asks the hazard logic to freeze the pipeline (PC_Write/II_Write low) through stall_req while an access would conflict with an in-flight operation. XLEN generalises the datapath width.

Parameters:
XLEN, 32, operand and HI/LO width (must be >=4)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  issue pulse for a mul/div op from ID/EX
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_val  input  XLEN  multiplicand / dividend
rt_val  input  XLEN  multiplier / divisor
flush  input  1  abort any in-flight op (taken branch from MEM)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wr_data  input  XLEN  MTHI/MTLO data
rd_hilo  input  1  MFHI/MFLO present in EX this cycle
busy  output  1  op in flight (state != IDLE)
stall_req  output  1  freeze request to hazard unit
done  output  1  one-cycle completion pulse
div_by_zero  output  1  valid with done; divisor was zero
hi  output  XLEN  HI register
lo  output  XLEN  LO register

Behaviour:
- Reset (sync, active-high, overrides everything): state=IDLE, hi=lo=0, done=0, div_by_zero=0, internal accumulators cleared.
- FSM: IDLE -> RUN (start accepted) -> FIX (after XLEN RUN cycles) -> IDLE.
- IDLE + start + !flush: latch op, magnitudes of operands (signed ops take two's-complement magnitude; unsigned ops take raw values), the sign flags, and a zero-divisor flag. Clear the iteration counter.
- RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle. Exactly XLEN cycles.
- FIX: apply the sign correction and write HI/LO. Then go to IDLE and assert done=1 on the next cycle.
  - Signed MULT: negate the 2*XLEN product when the operand signs differ.
  - Signed DIV: negate the quotient when the signs differ. The remainder takes the sign of the dividend.
- Latency: start sampled at edge 0; hi/lo updated and done=1 in the cycle after edge XLEN+1 (34 cycles for XLEN=32). done is high for exactly one cycle.
- MULT/MULTU: hi = upper XLEN bits of the product, lo = lower XLEN bits.
- DIV/DIVU: lo = quotient, hi = remainder.
- Divide by zero: same latency. lo = all ones, hi = rs_val as latched (original value, not magnitude), div_by_zero=1 with done.
- Signed overflow: DIV of most-negative by -1 gives lo = most-negative, hi = 0.
- MTHI/MTLO in IDLE: hi/lo take wr_data on the next edge; both may be written in the same cycle. If start is accepted in the same cycle, start wins and the writes are dropped.
- stall_req = busy & (start | rd_hilo | hi_we | lo_we). This signal is combinational.
  - While stalled, a start is not accepted. The hazard unit holds the instruction, and it re-presents start once busy=0.
  - hi_we/lo_we are ignored while busy.
- Reading hi/lo in the done cycle returns the new result.
- flush in RUN or FIX: next state IDLE. hi/lo are unchanged, no done pulse.
- flush in IDLE together with start: start is ignored.
- flush takes precedence over FIX completion.
- Back-to-back: a start in the done cycle is accepted (state is IDLE).

Decomposition:
- Shared package cpu_pkg holds:
  - the op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU;
  - the FSM state encoding (IDLE/RUN/FIX);
  - the width constant.
- No sub-module is needed. The counter, FSM and datapath live in one module of about 200 lines.

Test Plan:
1. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done exactly 34 cycles after start; hi=0xFFFFFFFE, lo=0x00000001, busy=1 for cycles 1..33.
2. MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
3. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1 with done.
4. During RUN, assert start, rd_hilo, and hi_we each for one cycle -> stall_req=1 in each of those cycles. The second op is not accepted and the hi_we is dropped. Final hi/lo come from the first op only.
5. MTHI 0x1234, MTLO 0x5678, then a MULT with flush at cycle 10 -> busy=0 next cycle, no done pulse, hi=0x1234, lo=0x5678.
6. rst asserted mid-RUN -> next cycle state IDLE, hi=lo=0, busy=0, done=0; a fresh MULTU 3x5 then gives lo=15, hi=0.
